// File: rtl/load_store_unit_if.sv
// Data-side memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_we, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store engine: decodes a memory request, runs one bus transaction with a
// wait-state timeout, and returns an extended load result for writeback.
module load_store_unit #(
   parameter int MAX_WAIT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      is_store,
   input  logic [2:0]                funct3,
   input  logic [31:0]               addr,
   input  logic [31:0]               wdata,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               rdata,
   output logic                      misaligned,
   output logic                      err,
   load_store_unit_if.master         mem
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state, state_next;

   logic        legal_in, misalign_in, accept, timeout;
   logic [3:0]  be_in;
   logic [31:0] wdata_in, load_value;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        we_q, err_q, mis_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [7:0]  wait_cnt;

   // Request decode straight from the start-cycle inputs; funct3[1:0] gives the access size.
   always_comb begin
      legal_in    = 1'b0;
      misalign_in = 1'b0;
      be_in       = 4'b0000;
      wdata_in    = wdata;
      case (funct3)
         3'b000, 3'b001, 3'b010: legal_in = 1'b1;
         3'b100, 3'b101:         legal_in = !is_store;
         default:                legal_in = 1'b0;
      endcase
      case (funct3[1:0])
         2'b00: begin
            be_in    = 4'b0001 << addr[1:0];
            wdata_in = {4{wdata[7:0]}};
         end
         2'b01: begin
            misalign_in = addr[0];
            be_in       = addr[1] ? 4'b1100 : 4'b0011;
            wdata_in    = {2{wdata[15:0]}};
         end
         default: begin
            misalign_in = (addr[1:0] != 2'b00);
            be_in       = 4'b1111;
            wdata_in    = wdata;
         end
      endcase
   end

   assign accept  = (state == IDLE) && start;
   assign timeout = (state == REQ) && !mem.mem_ready && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (!legal_in || misalign_in) ? DONE : REQ;
         REQ:  if (mem.mem_ready || timeout) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane selection uses the offset latched at start, not the live address input.
   always_comb begin
      byte_sel   = mem.mem_rdata[{off_q, 3'b000} +: 8];
      half_sel   = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
      load_value = mem.mem_rdata;
      case (f3_q)
         3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_value = {24'h000000, byte_sel};
         3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_value = {16'h0000, half_sel};
         default: load_value = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f3_q     <= 3'b000;
         off_q    <= 2'b00;
         we_q     <= 1'b0;
         be_q     <= 4'b0000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         wait_cnt <= 8'h00;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
      end else if (accept) begin
         f3_q     <= funct3;
         off_q    <= addr[1:0];
         we_q     <= is_store;
         be_q     <= be_in;
         addr_q   <= {addr[31:2], 2'b00};
         wdata_q  <= wdata_in;
         wait_cnt <= 8'h00;
         err_q    <= !legal_in;
         mis_q    <= legal_in && misalign_in;
      end else if (state == REQ) begin
         if (mem.mem_ready) begin
            if (!we_q) rdata_q <= load_value;
         end else begin
            wait_cnt <= wait_cnt + 8'h01;
            if (timeout) err_q <= 1'b1;
         end
      end
   end

   // Status and bus strobes are decoded from state so reset drops them immediately.
   assign busy          = (state == REQ);
   assign done          = (state == DONE);
   assign rdata         = rdata_q;
   assign err           = (state == DONE) && err_q;
   assign misaligned    = (state == DONE) && mis_q;
   assign mem.mem_valid = (state == REQ);
   assign mem.mem_we    = (state == REQ) && we_q;
   assign mem.mem_be    = (state == REQ) ? be_q : 4'b0000;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a memory slave with programmable wait
// states, an arithmetic reference model, and a monitor that checks each done pulse.
module tb_load_store_unit;

   localparam int MAX_WAIT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic        err;

   load_store_unit_if bus();

   load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .rdata      (rdata),
      .misaligned (misaligned),
      .err        (err),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      int          latency;
      int          vcycles;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic [3:0]  be;
      logic        we;
      int          start_cyc;
      logic        goes_req;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   int          wait_cycles = 0;
   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   logic [31:0] last_rdata = 32'h0;
   bit          reset_test = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Memory slave: raises mem_ready after wait_cycles stalled cycles and checks the bus fields.
   initial begin
      int cnt;
      int idx;
      cnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.mem_valid && !reset) begin
            if (cnt == wait_cycles) begin
               idx = int'(bus.mem_addr[5:2]);
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem[idx];
               if (sb_q.size() > 0) begin
                  checkOutput("bus_addr", bus.mem_addr, sb_q[0].baddr);
                  checkOutput("bus_be", {28'h0, bus.mem_be}, {28'h0, sb_q[0].be});
                  checkOutput("bus_we", {31'h0, bus.mem_we}, {31'h0, sb_q[0].we});
                  if (sb_q[0].we) checkOutput("bus_wdata", bus.mem_wdata, sb_q[0].bwdata);
               end
               if (bus.mem_we) begin
                  for (int i = 0; i < 4; i++)
                     if (bus.mem_be[i]) mem[idx][8*i +: 8] = bus.mem_wdata[8*i +: 8];
               end
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
            end
            cnt++;
         end else begin
            bus.mem_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: pops one expectation per done pulse; idle cycles must show no status flags.
   initial begin
      int   vcount;
      exp_t e;
      logic exp_busy;
      vcount = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            vcount = 0;
         end else begin
            if (bus.mem_valid) vcount++;
            if (done) begin
               checkOutput("busy_in_done", {31'h0, busy}, 32'h0);
               if (sb_q.size() == 0) begin
                  checkOutput("unexpected_done", {31'h0, done}, 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  checkOutput("rdata", rdata, e.rdata);
                  checkOutput("err", {31'h0, err}, {31'h0, e.err});
                  checkOutput("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
                  checkOutput("latency", 32'(cyc - e.start_cyc), 32'(e.latency));
                  checkOutput("valid_cycles", 32'(vcount), 32'(e.vcycles));
               end
               vcount = 0;
            end else begin
               checkOutput("err_idle", {31'h0, err}, 32'h0);
               checkOutput("mis_idle", {31'h0, misaligned}, 32'h0);
               if (!reset_test) begin
                  exp_busy = (sb_q.size() > 0) && (cyc > sb_q[0].start_cyc) && sb_q[0].goes_req;
                  checkOutput("busy", {31'h0, busy}, {31'h0, exp_busy});
               end
            end
         end
      end
   end

   // Issues one request, pushes the model's expectation, and pokes ignored starts while busy.
   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int waits,
                                input bit use_lit, input logic [31:0] lit);
      exp_t        e;
      int          off, idx, sz, guard;
      bit          legal, tmo;
      longint      field, mask;
      logic [31:0] wexp;
      off   = int'(a[1:0]);
      idx   = int'(a[5:2]);
      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz    = 1 << int'(f3[1:0]);
      mask  = ((longint'(1) << (8 * sz)) - 1) << (8 * off);
      wexp  = (sz == 1) ? (wd & 32'hff) * 32'h01010101 :
              (sz == 2) ? (wd & 32'hffff) * 32'h00010001 : wd;
      tmo   = (waits >= MAX_WAIT);
      e.err      = !legal;
      e.mis      = legal && ((off % sz) != 0);
      e.baddr    = a & ~32'h3;
      e.bwdata   = wexp;
      e.be       = 4'(((1 << sz) - 1) << off);
      e.we       = st;
      e.rdata    = last_rdata;
      e.goes_req = !(e.err || e.mis);
      if (!e.goes_req) begin
         e.latency = 1;
         e.vcycles = 0;
      end else if (tmo) begin
         e.err     = 1'b1;
         e.latency = 1 + MAX_WAIT;
         e.vcycles = MAX_WAIT;
      end else begin
         e.latency = 2 + waits;
         e.vcycles = 1 + waits;
         if (st) begin
            ref_mem[idx] = 32'((longint'(ref_mem[idx]) & ~mask) | (longint'(wexp) & mask));
         end else begin
            field = (longint'(ref_mem[idx]) & mask) >> (8 * off);
            if (f3 < 3'd4 && sz < 4 && field >= (longint'(1) << (8 * sz - 1)))
               field = field - (longint'(1) << (8 * sz));
            e.rdata = use_lit ? lit : 32'(field);
            last_rdata = e.rdata;
         end
      end
      wait_cycles = waits;
      is_store    = st;
      funct3      = f3;
      addr        = a;
      wdata       = wd;
      start       = 1'b1;
      e.start_cyc = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
         if ($urandom_range(0, 2) == 0) begin
            start    = 1'b1;
            is_store = 1'($urandom);
            funct3   = 3'($urandom);
            addr     = $urandom;
            wdata    = $urandom;
         end
         @(negedge clk);
         start = 1'b0;
         guard++;
      end
      if (!done) checkOutput("done_timeout", {31'h0, done}, 32'h1);
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      is_store = 1'b0;
      funct3   = 3'b000;
      addr     = 32'h0;
      wdata    = 32'h0;
      for (int i = 0; i < 16; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[10] = 32'hdeadbeef; ref_mem[10] = 32'hdeadbeef;
      mem[11] = 32'hcafebabe; ref_mem[11] = 32'hcafebabe;

      #1;
      checkOutput("rst_busy", {31'h0, busy}, 32'h0);
      checkOutput("rst_done", {31'h0, done}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_valid", {31'h0, bus.mem_valid}, 32'h0);
      checkOutput("rst_we", {31'h0, bus.mem_we}, 32'h0);
      checkOutput("rst_be", {28'h0, bus.mem_be}, 32'h0);
      checkOutput("rst_addr", bus.mem_addr, 32'h0);
      checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
      checkOutput("rst_err", {30'h0, err, misaligned}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 3'b010, 32'h000000a8, 32'h0, 0, 1'b1, 32'hdeadbeef);
      applyStimulus(1'b0, 3'b000, 32'h000000ab, 32'h0, 0, 1'b1, 32'hffffffde);
      applyStimulus(1'b0, 3'b100, 32'h000000a9, 32'h0, 0, 1'b1, 32'h000000be);
      applyStimulus(1'b0, 3'b001, 32'h000000aa, 32'h0, 0, 1'b1, 32'hffffdead);
      applyStimulus(1'b0, 3'b101, 32'h000000a8, 32'h0, 0, 1'b1, 32'h0000beef);
      applyStimulus(1'b1, 3'b000, 32'h000000a9, 32'h1234565a, 0, 1'b0, 32'h0);
      applyStimulus(1'b1, 3'b001, 32'h000000aa, 32'hcafebabe, 0, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h000000ac, 32'h0, 3, 1'b1, 32'hcafebabe);
      applyStimulus(1'b0, 3'b010, 32'h000000a6, 32'h0, 0, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b001, 32'h000000a9, 32'h0, 0, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b011, 32'h000000a8, 32'h0, 0, 1'b0, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'h000000a8, 32'h0, 0, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h000000a8, 32'h0, 255, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h000000a8, 32'h0, 15, 1'b0, 32'h0);

      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom,
                       ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4)),
                       1'b0, 32'h0);
      end

      // Reset in the middle of a stalled request must abort without a done pulse.
      reset_test  = 1'b1;
      wait_cycles = 255;
      is_store    = 1'b0;
      funct3      = 3'b010;
      addr        = 32'h000000a8;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pre_rst_valid", {31'h0, bus.mem_valid}, 32'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("midrst_valid", {31'h0, bus.mem_valid}, 32'h0);
      checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
      checkOutput("midrst_done", {31'h0, done}, 32'h0);
      checkOutput("midrst_rdata", rdata, 32'h0);
      repeat (2) @(negedge clk);
      reset      = 1'b0;
      last_rdata = 32'h0;
      @(negedge clk);
      checkOutput("post_rst_done", {31'h0, done}, 32'h0);
      reset_test = 1'b0;
      applyStimulus(1'b0, 3'b010, 32'h000000ac, 32'h0, 1, 1'b0, 32'h0);
      applyStimulus(1'b0, 3'b100, 32'h000000af, 32'h0, 0, 1'b0, 32'h0);

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
